// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receive framer.
// Brings the asynchronous serial line into the clock domain with a 2-flop
// synchronizer, finds a 1->0 start edge, confirms the start bit at mid-bit,
// shifts in UART_NUM_DATA data bits LSB first and checks the stop bit.
// A good frame loads uart_rdata and pulses uart_vld; a bad frame pulses
// frame_err and leaves uart_rdata untouched.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. Without it, DATA goes directly to STOP.
//
// Constraints: CLK_FREQ/BAUD_RATE must be at least 4 and UART_NUM_DATA at
// least 2.

module uart_rx_framer #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int UART_NUM_DATA = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     uart_rx,
    output logic [UART_NUM_DATA-1:0] uart_rdata,
    output logic                     uart_vld,
    output logic                     frame_err
);

    // Clocks per bit period, and the half-period used to confirm the start bit.
    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(UART_NUM_DATA + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity over data plus parity bit: any odd total is an error.
    function automatic logic parity_err_f(
        input logic [UART_NUM_DATA-1:0] data,
        input logic                     par_bit
    );
        return (^data) ^ par_bit;
    endfunction
`endif

    // Synchronizer stages; rx_s_q is the first usable sample, rx_s_dly_q
    // is that sample one cycle older for edge detection.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_s_dly_q;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [UART_NUM_DATA-1:0] shift_q;
    logic [UART_NUM_DATA-1:0] uart_rdata_q;
    logic                     uart_vld_q;
    logic                     frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                     par_err_q;
`endif

    logic start_edge_s;
    logic half_pt_s;
    logic bit_end_s;
    logic stop_ok_s;

    assign start_edge_s = rx_s_dly_q & ~rx_s_q;
    assign half_pt_s    = (cnt_q == CNT_W'(HALF - 1));
    assign bit_end_s    = (cnt_q == CNT_W'(DIV - 1));
`ifdef UART_RX_PARITY_EN
    assign stop_ok_s    = rx_s_q & ~par_err_q;
`else
    assign stop_ok_s    = rx_s_q;
`endif

    // Two-flop synchronizer plus one delay stage; reset to the idle-high level
    // so a release from reset never looks like a start edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_s_q     <= rx_meta_q;
            rx_s_dly_q <= rx_s_q;
        end
    end

    // Frame state machine with baud/bit counters, shift register and
    // registered result pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            bit_cnt_q    <= {BIT_W{1'b0}};
            shift_q      <= {UART_NUM_DATA{1'b0}};
            uart_rdata_q <= {UART_NUM_DATA{1'b0}};
            uart_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            uart_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= {CNT_W{1'b0}};
                    bit_cnt_q <= {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                    par_err_q <= 1'b0;
`endif
                    if (start_edge_s) begin
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (half_pt_s) begin
                        cnt_q <= {CNT_W{1'b0}};
                        // Still low at mid start bit: real frame. High: glitch.
                        if (!rx_s_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        shift_q <= {rx_s_q, shift_q[UART_NUM_DATA-1:1]};
                        if (bit_cnt_q == BIT_W'(UART_NUM_DATA - 1)) begin
                            bit_cnt_q <= {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_q     <= {CNT_W{1'b0}};
                        par_err_q <= parity_err_f(shift_q, rx_s_q);
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        // Leave at mid stop bit so a back-to-back start edge
                        // is seen from the first IDLE cycle.
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_IDLE;
                        if (stop_ok_s) begin
                            uart_rdata_q <= shift_q;
                            uart_vld_q   <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= {CNT_W{1'b0}};
                    bit_cnt_q <= {BIT_W{1'b0}};
                end
            endcase
        end
    end

    assign uart_rdata = uart_rdata_q;
    assign uart_vld   = uart_vld_q;
    assign frame_err  = frame_err_q;

    uart_rx_framer_chk u_chk (
        .clk       (clk),
        .nrst      (nrst),
        .uart_vld  (uart_vld_q),
        .frame_err (frame_err_q)
    );

endmodule

// Property checker for the result pulses of uart_rx_framer.
module uart_rx_framer_chk (
    input logic clk,
    input logic nrst,
    input logic uart_vld,
    input logic frame_err
);

    // A frame is either accepted or rejected, never both.
    a_vld_err_excl: assert property (@(posedge clk) disable iff (!nrst)
        !(uart_vld && frame_err));

    // Result pulses last exactly one cycle.
    a_vld_pulse: assert property (@(posedge clk) disable iff (!nrst)
        uart_vld |=> !uart_vld);

    a_err_pulse: assert property (@(posedge clk) disable iff (!nrst)
        frame_err |=> !frame_err);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomized self-checking bench for uart_rx_framer (DIV = 10).
// Frames are described as bit lists; the reference model decides from the
// frame contents alone whether each frame should be accepted or rejected.
module tb_uart_rx_framer;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int N        = 8;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit USE_PAR  = 1'b1;
`else
    localparam bit USE_PAR  = 1'b0;
`endif
    localparam int STOP_IDX = 1 + N + (USE_PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         nrst;
    logic         uart_rx;
    logic [N-1:0] uart_rdata;
    logic         uart_vld;
    logic         frame_err;

    uart_rx_framer #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD),
        .UART_NUM_DATA (N)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .uart_rx    (uart_rx),
        .uart_rdata (uart_rdata),
        .uart_vld   (uart_vld),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation side.
    int           cyc = 0;
    logic [N-1:0] got_q[$];
    int           err_seen  = 0;
    int           both_seen = 0;
    int           hold_viol = 0;
    int           last_vld_cyc = 0;
    logic [N-1:0] prev_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nrst) begin
            if (uart_vld) begin
                got_q.push_back(uart_rdata);
                last_vld_cyc = cyc;
            end
            if (frame_err) err_seen++;
            if (uart_vld && frame_err) both_seen++;
            if (!uart_vld && (uart_rdata !== prev_rdata)) hold_viol++;
        end
        prev_rdata = uart_rdata;
    end

    // Reference model state.
    logic [N-1:0] exp_q[$];
    int           exp_err = 0;
    logic [N-1:0] model_rdata = '0;
    int           frame_start_cyc = 0;
    logic         frame_bits[$];

    task automatic idle(input int n);
        uart_rx = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame();
        foreach (frame_bits[k]) begin
            uart_rx = frame_bits[k];
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame_full(input logic [N-1:0] d, input logic stop_b,
                                   input logic par_b, input logic use_par);
        logic ok;
        frame_bits.delete();
        frame_bits.push_back(1'b0);
        for (int i = 0; i < N; i++) frame_bits.push_back(d[i]);
        if (use_par) frame_bits.push_back(par_b);
        frame_bits.push_back(stop_b);
        frame_start_cyc = cyc;
        drive_frame();
        ok = stop_b && (!use_par || (((^d) ^ par_b) == 1'b0));
        if (ok) begin
            exp_q.push_back(d);
            model_rdata = d;
        end else begin
            exp_err++;
        end
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_b);
        send_frame_full(d, stop_b, ^d, USE_PAR);
    endtask

    task automatic compare_sb(input string tag);
        int n;
        check_eq({tag, "_nvld"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_data%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_nerr"}, 32'(err_seen), 32'(exp_err));
        check_eq({tag, "_rdata"}, 32'(uart_rdata), 32'(model_rdata));
        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    initial begin
        int lat;
        nrst    = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", 32'(uart_rdata), 32'h0);
        check_eq("rst_vld",   32'(uart_vld),   32'h0);
        check_eq("rst_err",   32'(frame_err),  32'h0);
        nrst = 1'b1;
        idle(3 * DIV);

        // Single good frame and its latency from the stop-bit middle.
        send_frame(8'hCB, 1'b1);
        lat = last_vld_cyc - frame_start_cyc;
        check_eq("lat_cb", 32'((lat >= STOP_IDX * DIV + HALF) && (lat <= STOP_IDX * DIV + HALF + 5)), 32'h1);
        idle(2 * DIV);
        compare_sb("cb");

        // Back-to-back frames, no idle gap.
        send_frame(8'hAD, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(2 * DIV);
        compare_sb("b2b");

        // Short glitch on an idle line, then a clean frame to show recovery.
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3 * DIV);
        compare_sb("glitch");
        send_frame(8'h96, 1'b1);
        idle(2 * DIV);
        compare_sb("post_glitch");

        // Bad stop bit.
        send_frame(8'h3C, 1'b0);
        idle(2 * DIV);
        compare_sb("badstop");

        // Break: line held low well beyond a frame gives one error only.
        send_frame(8'h00, 1'b0);
        repeat (4 * 10 * DIV) @(posedge clk);
        #1;
        idle(2 * DIV);
        compare_sb("break");

        // Reset in the middle of data bit 4 of 8'hFF.
        uart_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4 * DIV + HALF) @(posedge clk);
        #1;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        #1;
        check_eq("mrst_rdata", 32'(uart_rdata), 32'h0);
        check_eq("mrst_vld",   32'(uart_vld),   32'h0);
        check_eq("mrst_err",   32'(frame_err),  32'h0);
        model_rdata = '0;
        idle(8 * DIV);
        compare_sb("mrst");
        send_frame(8'h01, 1'b1);
        idle(2 * DIV);
        compare_sb("post_rst");

`ifdef UART_RX_PARITY_EN
        send_frame_full(8'h07, 1'b1, 1'b0, 1'b1);
        idle(2 * DIV);
        compare_sb("par_bad");
        send_frame_full(8'h07, 1'b1, 1'b1, 1'b1);
        idle(2 * DIV);
        compare_sb("par_good");
`endif

        // Randomized mix of good frames, bad frames, glitches and gaps.
        for (int it = 0; it < 40; it++) begin
            int           kind;
            logic [N-1:0] d;
            kind = $urandom_range(0, 9);
            d    = N'($urandom);
            if (kind == 0) begin
                idle(DIV);
                uart_rx = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                idle(2 * DIV);
            end else if (kind == 1) begin
                send_frame_full(d, 1'b0, ^d, USE_PAR);
                idle(DIV + $urandom_range(0, DIV));
            end else if (kind == 2 && USE_PAR) begin
                send_frame_full(d, 1'b1, ~(^d), USE_PAR);
                idle($urandom_range(0, DIV));
            end else begin
                send_frame(d, 1'b1);
                idle($urandom_range(0, DIV));
            end
            if ((it % 10) == 9) begin
                idle(2 * DIV);
                compare_sb($sformatf("rand%0d", it));
            end
        end

        check_eq("vld_err_overlap", 32'(both_seen), 32'h0);
        check_eq("rdata_hold",      32'(hold_viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
